// File: rtl/ctrl_unit_if.sv
// Bus between the control/execute stage, the PC, instruction memory and data memory.
// The slave side is ctrl_unit; the master side is the surrounding system.
interface ctrl_unit_if #(
    parameter int ACC_W  = 8,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addr_i;
    logic [7:0]        instr_i;
    logic              jmp_en_o;
    logic [ADDR_W-1:0] jmp_addr_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [ACC_W-1:0]  dmem_data_i;
    logic              dmem_we_o;
    logic [ACC_W-1:0]  dmem_wdata_o;
    logic [ACC_W-1:0]  acc_o;
    logic              zero_o;
    logic              carry_o;
    logic              halt_o;

    modport slave (
        input  addr_i, instr_i, dmem_data_i,
        output jmp_en_o, jmp_addr_o, dmem_addr_o, dmem_we_o, dmem_wdata_o,
               acc_o, zero_o, carry_o, halt_o
    );

    modport master (
        output addr_i, instr_i, dmem_data_i,
        input  jmp_en_o, jmp_addr_o, dmem_addr_o, dmem_we_o, dmem_wdata_o,
               acc_o, zero_o, carry_o, halt_o
    );
endinterface

// File: rtl/ctrl_unit.sv
// Control/execute stage of the accumulator computer: fetch register plus combinational
// execute of the IR, owning ACC, Z/C flags, the data-memory port and the PC jump request.
module ctrl_unit #(
    parameter int ACC_W  = 8,
    parameter int ADDR_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ctrl_unit_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t            state_r;
    state_t            state_nx_s;
    logic [7:0]        ir_r;
    logic [ADDR_W-1:0] ir_pc_r;
    logic              ir_valid_r;
    logic [ACC_W-1:0]  acc_r;
    logic              zero_r;
    logic              carry_r;

    logic [2:0]        op_s;
    logic [ADDR_W-1:0] opnd_s;
    logic              exec_s;
    logic [ACC_W:0]    sum_s;
    logic [ACC_W:0]    diff_s;
    logic [ACC_W-1:0]  acc_nx_s;
    logic              zero_nx_s;
    logic              carry_nx_s;
    logic              jmp_en_s;
    logic [ADDR_W-1:0] jmp_addr_s;
    logic              we_s;

    assign op_s   = ir_r[7:5];
    assign opnd_s = ir_r[ADDR_W-1:0];
    assign exec_s = ir_valid_r && (state_r == ST_RUN);
    assign sum_s  = {1'b0, acc_r} + {1'b0, bus.dmem_data_i};
    assign diff_s = {1'b0, acc_r} - {1'b0, bus.dmem_data_i};

    // Decode the IR into next ACC/flags/state and the jump and write requests.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        zero_nx_s  = zero_r;
        carry_nx_s = carry_r;
        jmp_en_s   = 1'b0;
        jmp_addr_s = opnd_s;
        we_s       = 1'b0;
        if (state_r == ST_HALT) begin
            jmp_en_s   = 1'b1;
            jmp_addr_s = ir_pc_r;
        end else if (exec_s) begin
            case (op_s)
                OP_NOP: ;
                OP_LDA: begin
                    acc_nx_s  = bus.dmem_data_i;
                    zero_nx_s = (bus.dmem_data_i == {ACC_W{1'b0}});
                end
                OP_STA: we_s = 1'b1;
                OP_ADD: begin
                    acc_nx_s   = sum_s[ACC_W-1:0];
                    carry_nx_s = sum_s[ACC_W];
                    zero_nx_s  = (sum_s[ACC_W-1:0] == {ACC_W{1'b0}});
                end
                OP_SUB: begin
                    // Bit ACC_W of the widened difference is the borrow (ACC < M).
                    acc_nx_s   = diff_s[ACC_W-1:0];
                    carry_nx_s = diff_s[ACC_W];
                    zero_nx_s  = (diff_s[ACC_W-1:0] == {ACC_W{1'b0}});
                end
                OP_JMP: jmp_en_s = 1'b1;
                OP_JZ: begin
                    if (zero_r) begin
                        jmp_en_s = 1'b1;
                    end else begin
                        jmp_en_s = 1'b0;
                    end
                end
                OP_HLT: begin
                    jmp_en_s   = 1'b1;
                    jmp_addr_s = ir_pc_r;
                    state_nx_s = ST_HALT;
                end
                default: ;
            endcase
        end else begin
            jmp_en_s = 1'b0;
        end
    end

    // Architectural state: FSM, accumulator and flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
            acc_r   <= {ACC_W{1'b0}};
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            acc_r   <= acc_nx_s;
            zero_r  <= zero_nx_s;
            carry_r <= carry_nx_s;
        end
    end

    // Fetch register; a jump holds IR/ir_pc and drops the wrong-path instruction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ir_r       <= 8'h00;
            ir_pc_r    <= {ADDR_W{1'b0}};
            ir_valid_r <= 1'b0;
        end else if (jmp_en_s) begin
            ir_valid_r <= 1'b0;
        end else begin
            ir_r       <= bus.instr_i;
            ir_pc_r    <= bus.addr_i;
            ir_valid_r <= 1'b1;
        end
    end

    // Reset masks the jump and write requests even when the IR holds a valid JMP/STA.
    assign bus.jmp_en_o     = jmp_en_s & ~rst_i;
    assign bus.jmp_addr_o   = jmp_addr_s;
    assign bus.dmem_we_o    = we_s & ~rst_i;
    assign bus.dmem_addr_o  = opnd_s;
    assign bus.dmem_wdata_o = acc_r;
    assign bus.acc_o        = acc_r;
    assign bus.zero_o       = zero_r;
    assign bus.carry_o      = carry_r;
    assign bus.halt_o       = (state_r == ST_HALT);
endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: PC and memory models around the DUT, table-driven ALU programs
// plus hand-written jump/halt/reset sequences, data writes checked by a scoreboard.
module tb_ctrl_unit;
    localparam int ACC_W  = 8;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_unit_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();
    ctrl_unit #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    logic [7:0] imem [32];
    logic [7:0] dmem [32];
    logic [4:0] pc;

    always_ff @(posedge clk) begin
        if (rst)                pc <= 5'd0;
        else if (bus.jmp_en_o)  pc <= bus.jmp_addr_o;
        else                    pc <= pc + 5'd1;
    end

    assign bus.addr_i      = pc;
    assign bus.instr_i     = imem[pc];
    assign bus.dmem_data_i = dmem[bus.dmem_addr_o];

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
        logic       z;
        logic       c;
    } wr_t;
    wr_t sb_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt, jmp_cnt, j25_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [7:0] d, input logic z, input logic c);
        wr_t e;
        e.addr = a; e.data = d; e.z = z; e.c = c;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every data-memory write pops the oldest expected write.
    always @(negedge clk) begin : sb_mon
        wr_t e;
        if (!rst && bus.dmem_we_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: write addr %0d data %0h, required no write",
                         bus.dmem_addr_o, bus.dmem_wdata_o);
            end else begin
                e = sb_q.pop_front();
                check("sb_addr",  32'(bus.dmem_addr_o),  32'(e.addr));
                check("sb_data",  32'(bus.dmem_wdata_o), 32'(e.data));
                check("sb_zero",  32'(bus.zero_o),       32'(e.z));
                check("sb_carry", 32'(bus.carry_o),      32'(e.c));
            end
        end
    end

    task automatic step();
        logic       wr_v;
        logic [4:0] wa;
        logic [7:0] wd;
        @(negedge clk);
        wr_v = bus.dmem_we_o && !rst;
        wa   = bus.dmem_addr_o;
        wd   = bus.dmem_wdata_o;
        if (wr_v) we_cnt++;
        if (bus.jmp_en_o && !bus.halt_o && !rst) jmp_cnt++;
        if (bus.jmp_en_o && (bus.jmp_addr_o == 5'd25) && !rst) j25_cnt++;
        @(posedge clk);
        if (wr_v) dmem[wa] = wd;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            imem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        we_cnt = 0; jmp_cnt = 0; j25_cnt = 0;
        sb_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        for (int i = 0; i < budget && !bus.halt_o; i++) step();
        check("halt_reached", 32'(bus.halt_o), 32'd1);
    endtask

    typedef struct {
        logic [7:0] op_instr;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_acc;
        logic       exp_z;
        logic       exp_c;
    } vec_t;
    vec_t vt [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ADD 21 = 8'h75, SUB 21 = 8'h95, LDA 21 = 8'h35
        vt[0] = '{8'h75, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1};
        vt[1] = '{8'h75, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1};
        vt[2] = '{8'h75, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vt[3] = '{8'h75, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vt[4] = '{8'h95, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vt[5] = '{8'h95, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
        vt[6] = '{8'h95, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};
        vt[7] = '{8'h35, 8'h77, 8'h00, 8'h00, 1'b1, 1'b0};

        // Reset values, with jump/write requests masked, then a NOP program counting up.
        for (int i = 0; i < 32; i++) imem[i] = 8'hB9;
        rst = 1'b1;
        step();
        check("rst_acc",    32'(bus.acc_o),     32'd0);
        check("rst_zero",   32'(bus.zero_o),    32'd0);
        check("rst_carry",  32'(bus.carry_o),   32'd0);
        check("rst_halt",   32'(bus.halt_o),    32'd0);
        check("rst_jmp_en", 32'(bus.jmp_en_o),  32'd0);
        check("rst_we",     32'(bus.dmem_we_o), 32'd0);
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            check("nop_pc",     32'(pc),           32'(k));
            check("nop_jmp_en", 32'(bus.jmp_en_o), 32'd0);
        end

        // Table: LDA 20; <op> 21; STA 30; HLT
        for (int v = 0; v < 8; v++) begin
            do_reset();
            dmem[20] = vt[v].a;
            dmem[21] = vt[v].b;
            imem[0] = 8'h34;
            imem[1] = vt[v].op_instr;
            imem[2] = 8'h5E;
            imem[3] = 8'hE0;
            expect_wr(5'd30, vt[v].exp_acc, vt[v].exp_z, vt[v].exp_c);
            run_to_halt(20);
            check("tbl_acc",      32'(bus.acc_o),      32'(vt[v].exp_acc));
            check("tbl_halt_adr", 32'(bus.jmp_addr_o), 32'd3);
            check("tbl_pc_hold",  32'(pc),             32'd3);
            check("tbl_we_cnt",   32'(we_cnt),         32'd1);
            check("tbl_dmem30",   32'(dmem[30]),       32'(vt[v].exp_acc));
            check("tbl_sb_drain", 32'(sb_q.size()),    32'd0);
        end

        // Taken JZ: LDA 20; SUB 20; JZ 25; STA 30 (flushed); 25: STA 31; HLT
        do_reset();
        dmem[20] = 8'h05;
        imem[0] = 8'h34; imem[1] = 8'h94; imem[2] = 8'hD9; imem[3] = 8'h5E;
        imem[25] = 8'h5F; imem[26] = 8'hE0;
        expect_wr(5'd31, 8'h00, 1'b1, 1'b0);
        run_to_halt(30);
        check("jz_j25_cnt",  32'(j25_cnt),        32'd1);
        check("jz_jmp_cnt",  32'(jmp_cnt),        32'd2);
        check("jz_we_cnt",   32'(we_cnt),         32'd1);
        check("jz_halt_adr", 32'(bus.jmp_addr_o), 32'd26);
        check("jz_sb_drain", 32'(sb_q.size()),    32'd0);

        // Not-taken JZ: LDA 20; JZ 25; STA 30; HLT
        do_reset();
        dmem[20] = 8'h05;
        imem[0] = 8'h34; imem[1] = 8'hD9; imem[2] = 8'h5E; imem[3] = 8'hE0;
        expect_wr(5'd30, 8'h05, 1'b0, 1'b0);
        run_to_halt(30);
        check("jznt_j25_cnt",  32'(j25_cnt),     32'd0);
        check("jznt_jmp_cnt",  32'(jmp_cnt),     32'd1);
        check("jznt_sb_drain", 32'(sb_q.size()), 32'd0);

        // STA then LDA of the same address: LDA 20; STA 30; LDA 21; LDA 30; STA 31; HLT
        do_reset();
        dmem[20] = 8'h5A;
        imem[0] = 8'h34; imem[1] = 8'h5E; imem[2] = 8'h35; imem[3] = 8'h3E;
        imem[4] = 8'h5F; imem[5] = 8'hE0;
        expect_wr(5'd30, 8'h5A, 1'b0, 1'b0);
        expect_wr(5'd31, 8'h5A, 1'b0, 1'b0);
        run_to_halt(30);
        check("sta_we_cnt",   32'(we_cnt),       32'd2);
        check("sta_dmem31",   32'(dmem[31]),     32'h5A);
        check("sta_sb_drain", 32'(sb_q.size()),  32'd0);

        // HLT at 6 holds PC and ACC until reset.
        do_reset();
        dmem[20] = 8'h33;
        imem[0] = 8'h34; imem[6] = 8'hE0;
        run_to_halt(30);
        for (int k = 0; k < 12; k++) begin
            step();
            check("hlt_halt",   32'(bus.halt_o),     32'd1);
            check("hlt_jmp_en", 32'(bus.jmp_en_o),   32'd1);
            check("hlt_addr",   32'(bus.jmp_addr_o), 32'd6);
            check("hlt_pc",     32'(pc),             32'd6);
            check("hlt_acc",    32'(bus.acc_o),      32'h33);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hlt_rst_halt", 32'(bus.halt_o), 32'd0);
        check("hlt_rst_pc",   32'(pc),         32'd0);
        check("hlt_rst_acc",  32'(bus.acc_o),  32'd0);
        step();
        check("hlt_rst_run_pc", 32'(pc), 32'd1);

        // Reset during the JMP 25 execute cycle: 25 must never execute.
        do_reset();
        imem[0] = 8'hB9; imem[25] = 8'h5F; imem[26] = 8'hE0;
        step();
        check("rj_jmp_en_pre", 32'(bus.jmp_en_o),   32'd1);
        check("rj_addr_pre",   32'(bus.jmp_addr_o), 32'd25);
        rst = 1'b1;
        #1;
        check("rj_jmp_en_rst", 32'(bus.jmp_en_o),  32'd0);
        check("rj_we_rst",     32'(bus.dmem_we_o), 32'd0);
        step();
        check("rj_pc", 32'(pc), 32'd0);
        imem[0] = 8'hE0;
        rst = 1'b0;
        run_to_halt(20);
        check("rj_halt_adr", 32'(bus.jmp_addr_o), 32'd0);
        check("rj_we_cnt",   32'(we_cnt),         32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Control/execute stage of the accumulator computer, downstream of `pc`. It captures the instruction that instruction memory returns for the PC's current address and executes it one cycle later. It owns the accumulator, the Z/C flags and the data-memory port. It drives the PC's jump inputs for JMP, taken JZ and HLT.

## Interface
- `ACC_W`, 8, accumulator and data width
- `ADDR_W`, 5, address width; must equal the PC width
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  synchronous, active-high reset; priority over all other inputs
- `addr_i`  in  ADDR_W  current PC (`pc.addr_o`)
- `instr_i`  in  8  instruction memory read data for `addr_i` (combinational); [7:5] opcode, [4:0] operand address
- `jmp_en_o`  out  1  to `pc.jmp_en_i`
- `jmp_addr_o`  out  ADDR_W  to `pc.jmp_addr_i`
- `dmem_addr_o`  out  ADDR_W  data memory address
- `dmem_data_i`  in  ACC_W  data memory read data (combinational)
- `dmem_we_o`  out  1  data memory write enable; write occurs on the edge
- `dmem_wdata_o`  out  ACC_W  write data (= ACC)
- `acc_o`  out  ACC_W  accumulator
- `zero_o`, `carry_o`  out  1  Z and C flags
- `halt_o`  out  1  high in HALT state

## Operation
- Two stages: fetch register (IR, `ir_pc`, `ir_valid`) and execute (combinational decode of IR).
- Every edge, unless flushing: IR <= `instr_i`, `ir_pc` <= `addr_i`, `ir_valid` <= 1.
- Opcodes (M = `dmem_data_i` at `dmem_addr_o` = IR[4:0]):
  - 000 NOP: no effect.
  - 001 LDA: ACC <= M; Z updated; C unchanged.
  - 010 STA: `dmem_we_o` = 1; ACC and flags unchanged.
  - 011 ADD: {C,ACC} <= ACC + M (9-bit sum); Z = (ACC == 0).
  - 100 SUB: ACC <= ACC − M mod 2^8; C = 1 iff ACC < M (borrow); Z updated.
  - 101 JMP: `jmp_en_o` = 1, `jmp_addr_o` = IR[4:0].
  - 110 JZ: as JMP iff the registered Z = 1; otherwise NOP.
  - 111 HLT: `jmp_en_o` = 1, `jmp_addr_o` = `ir_pc`; next state HALT.
- Instructions execute only when `ir_valid` = 1 and state = RUN.
- Flush: on any edge where `jmp_en_o` = 1, `ir_valid` <= 0. The wrong-path instruction is discarded.
- FSM:
  - RUN -> HALT on an executed HLT.
  - HALT -> RUN only via `rst_i`.
  - In HALT: `jmp_en_o` = 1, `jmp_addr_o` = halt address (registered `ir_pc` of the HLT), `ir_valid` held 0, ACC/flags frozen, `dmem_we_o` = 0.
- Reset values:
  - `acc_o` = 0, `zero_o` = 0, `carry_o` = 0, `halt_o` = 0, state RUN, `ir_valid` = 0.
  - While `rst_i` = 1, `jmp_en_o` = 0 and `dmem_we_o` = 0 combinationally, even if the IR holds a valid JMP/STA.
- When not jumping or halted, `jmp_addr_o` = IR[4:0]. The value is don't-care.

## Timing
- Instruction at address A: PC shows A in cycle n; IR loaded at the end of n; execute in n+1; ACC/flags/memory written at the end of n+1.
- JZ reads Z as registered. A JZ immediately after ADD/SUB sees that result, so there is no hazard stall.
- Taken jump costs 1 bubble:
  - the A+1 instruction is fetched but flushed;
  - the target is fetched in n+2 and executed in n+3.
- STA followed by LDA of the same address returns the stored value, because the write lands before the LDA execute cycle.
- HLT:
  - in the execute cycle, `jmp_en_o` = 1 with `jmp_addr_o` = A;
  - from the next cycle, `halt_o` = 1 and PC holds A indefinitely.
- Reset during any cycle, including HALT or a pending jump: after the edge, all state is at reset values. PC and `ctrl_unit` restart together at address 0. The first execute happens 2 cycles after reset release.

## Test plan
- Reset 1 cycle -> `acc_o`=0x00, `zero_o`=0, `carry_o`=0, `halt_o`=0, `jmp_en_o`=0, `dmem_we_o`=0; a NOP program runs with PC counting 0,1,2...
- mem[20]=0xF0, mem[21]=0x20; LDA 20; ADD 21 -> `acc_o`=0x10, `carry_o`=1, `zero_o`=0.
- mem[20]=0x05; LDA 20; SUB 20; JZ 25 with STA 30 at the next address -> `acc_o`=0, Z=1, C=0. `jmp_en_o` is high exactly one cycle with `jmp_addr_o`=25. `dmem_we_o` never rises for STA 30. The next executed `ir_pc` is 25.
- mem[20]=0x5A; LDA 20; STA 30 -> one cycle with `dmem_we_o`=1, `dmem_addr_o`=30, `dmem_wdata_o`=0x5A.
- HLT at address 6 -> `halt_o`=1, `jmp_en_o` stays 1 with `jmp_addr_o`=6, `addr_i` stays 6 for ≥10 cycles, `acc_o` unchanged. Asserting `rst_i` restores RUN at address 0.
- `rst_i` asserted during a JMP 25 execute cycle -> `jmp_en_o`=0 that cycle; PC is 0 afterwards and no instruction at 25 executes.
